// File: rtl/i2c_line_filter.sv
// I2C input conditioning: 2-flop synchronisers, per-line spike filter,
// SCL edge pulses, START/STOP detection and bus-busy tracking.
module i2c_line_filter #(
   parameter int unsigned filter_len = 3
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_o,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o,
   output logic busy_o,
   output logic glitch_o
);

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned LINES   = 2;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(filter_len - 1);

   // Line index 0 is SCL, index 1 is SDA.
   logic [LINES-1:0]            r_s1;
   logic [LINES-1:0]            r_s2;
   logic [LINES-1:0]            r_filt;
   logic [LINES-1:0]            r_filt_d;
   logic [LINES-1:0][CNT_W-1:0] r_cnt;
   logic                        r_rise;
   logic                        r_fall;
   logic                        r_start;
   logic                        r_stop;
   logic                        r_busy;
   logic                        r_glitch;

   logic [LINES-1:0]            w_filt_nxt;
   logic [LINES-1:0][CNT_W-1:0] w_cnt_nxt;
   logic                        w_glitch_nxt;
   logic                        w_rise_nxt;
   logic                        w_fall_nxt;
   logic                        w_start_nxt;
   logic                        w_stop_nxt;
   logic                        w_busy_nxt;

   // Persistence filter: a new level must be seen filter_len cycles in a row.
   always_comb begin
      w_filt_nxt   = r_filt;
      w_cnt_nxt    = '0;
      w_glitch_nxt = 1'b0;
      for (int i = 0; i < LINES; i++) begin
         if (r_s2[i] == r_filt[i]) begin
            w_cnt_nxt[i] = '0;
            if (r_cnt[i] != '0) begin
               w_glitch_nxt = 1'b1;
            end
         end else if (r_cnt[i] == CNT_MAX) begin
            w_filt_nxt[i] = r_s2[i];
            w_cnt_nxt[i]  = '0;
         end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
         end
      end
   end

   // Events from filtered levels; a simultaneous SCL change masks START/STOP.
   always_comb begin
      w_rise_nxt  = r_filt[0] & ~r_filt_d[0];
      w_fall_nxt  = ~r_filt[0] & r_filt_d[0];
      w_start_nxt = r_filt[0] & r_filt_d[0] & ~r_filt[1] & r_filt_d[1];
      w_stop_nxt  = r_filt[0] & r_filt_d[0] & r_filt[1] & ~r_filt_d[1];
      w_busy_nxt  = r_busy;
      if (w_start_nxt) begin
         w_busy_nxt = 1'b1;
      end else if (w_stop_nxt) begin
         w_busy_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_s1     <= '1;
         r_s2     <= '1;
         r_filt   <= '1;
         r_filt_d <= '1;
         r_cnt    <= '0;
         r_rise   <= 1'b0;
         r_fall   <= 1'b0;
         r_start  <= 1'b0;
         r_stop   <= 1'b0;
         r_busy   <= 1'b0;
         r_glitch <= 1'b0;
      end else begin
         r_s1     <= {sda_i, scl_i};
         r_s2     <= r_s1;
         r_filt   <= w_filt_nxt;
         r_filt_d <= r_filt;
         r_cnt    <= w_cnt_nxt;
         r_rise   <= w_rise_nxt;
         r_fall   <= w_fall_nxt;
         r_start  <= w_start_nxt;
         r_stop   <= w_stop_nxt;
         r_busy   <= w_busy_nxt;
         r_glitch <= w_glitch_nxt;
      end
   end

   assign scl_o      = r_filt[0];
   assign sda_o      = r_filt[1];
   assign scl_rise_o = r_rise;
   assign scl_fall_o = r_fall;
   assign start_o    = r_start;
   assign stop_o     = r_stop;
   assign busy_o     = r_busy;
   assign glitch_o   = r_glitch;

endmodule

// File: tb/tb_i2c_line_filter.sv
// Scoreboard bench for i2c_line_filter: a window-based reference model predicts
// every output cycle, plus directed event counts taken from the bus scenarios.
module tb_i2c_line_filter;

   localparam int unsigned FL    = 3;
   localparam int unsigned HLEN  = 20;
   localparam logic [7:0]  RST_V = 8'b1100_0000;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   logic scl_i = 1'b1;
   logic sda_i = 1'b1;
   logic scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, stop_o, busy_o, glitch_o;

   int checks = 0;
   int failures = 0;

   int n_rise = 0, n_fall = 0, n_start = 0, n_stop = 0, n_glitch = 0;

   logic [7:0] exp_q[$];

   // Model state: raw sample history (bit0 SCL, bit1 SDA), filtered levels now and one cycle ago.
   bit [1:0] hist[$];
   bit [1:0] mf, md;
   bit       mbusy;

   i2c_line_filter #(.filter_len(FL)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .scl_i      (scl_i),
      .sda_i      (sda_i),
      .scl_o      (scl_o),
      .sda_o      (sda_o),
      .scl_rise_o (scl_rise_o),
      .scl_fall_o (scl_fall_o),
      .start_o    (start_o),
      .stop_o     (stop_o),
      .busy_o     (busy_o),
      .glitch_o   (glitch_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [7:0] out_vec();
      return {scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, stop_o, busy_o, glitch_o};
   endfunction

   task automatic check_vec(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %b expected %b (scl sda rise fall start stop busy glitch)",
                  name, $time, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: a line flips when the last FL synchronised samples all
   // disagree with its filtered level; a spike is a return to the level right
   // after a disagreeing sample that did not get accepted.
   always @(posedge clk_i) begin
      bit [1:0] nf;
      bit       g, rise, fall, st, sp, all_diff;
      if (!rst_ni) begin
         hist = {};
         for (int j = 0; j < HLEN; j++) hist.push_back(2'b11);
         mf = 2'b11;
         md = 2'b11;
         mbusy = 1'b0;
         exp_q.push_back(RST_V);
      end else begin
         nf = mf;
         g  = 1'b0;
         for (int i = 0; i < 2; i++) begin
            all_diff = 1'b1;
            for (int j = 1; j <= int'(FL); j++)
               if (hist[j][i] == mf[i]) all_diff = 1'b0;
            if (all_diff) nf[i] = ~mf[i];
            if (hist[1][i] == mf[i] && hist[2][i] != mf[i]) g = 1'b1;
         end
         rise = mf[0] && !md[0];
         fall = !mf[0] && md[0];
         st   = mf[0] && md[0] && !mf[1] && md[1];
         sp   = mf[0] && md[0] && mf[1] && !md[1];
         if (st) mbusy = 1'b1;
         else if (sp) mbusy = 1'b0;
         exp_q.push_back({nf[0], nf[1], rise, fall, st, sp, mbusy, g});
         md = mf;
         mf = nf;
         hist.push_front({sda_i, scl_i});
         void'(hist.pop_back());
      end
   end

   // Monitor: one full output comparison per clock, plus event tallies from the DUT.
   always @(posedge clk_i) begin
      logic [7:0] act;
      #1;
      act = out_vec();
      if (exp_q.size() > 0) check_vec("cycle", act, exp_q.pop_front());
      if (scl_rise_o) n_rise++;
      if (scl_fall_o) n_fall++;
      if (start_o)    n_start++;
      if (stop_o)     n_stop++;
      if (glitch_o)   n_glitch++;
   end

   task automatic drive(input bit scl, input bit sda, input int n);
      scl_i = scl;
      sda_i = sda;
      repeat (n) @(negedge clk_i);
   endtask

   int s_rise, s_fall, s_start, s_stop, s_glitch;

   task automatic snap();
      s_rise = n_rise; s_fall = n_fall; s_start = n_start; s_stop = n_stop; s_glitch = n_glitch;
   endtask

   initial begin
      bit b;
      rst_ni = 1'b0;
      scl_i  = 1'b1;
      sda_i  = 1'b1;
      repeat (4) @(negedge clk_i);
      rst_ni = 1'b1;
      snap();

      // Idle after reset.
      drive(1, 1, 20);
      check_int("idle_events", (n_rise - s_rise) + (n_fall - s_fall) + (n_start - s_start)
                + (n_stop - s_stop) + (n_glitch - s_glitch), 0);
      check_int("idle_busy", int'(busy_o), 0);

      // START.
      snap();
      drive(1, 0, 12);
      check_int("start_count", n_start - s_start, 1);
      check_int("start_busy", int'(busy_o), 1);

      // Nine SCL clocks, SDA moving only while SCL is low.
      snap();
      b = 1'b0;
      for (int k = 0; k < 9; k++) begin
         drive(0, b, 5);
         b = 1'($urandom_range(0, 1));
         drive(0, b, 5);
         drive(1, b, 10);
      end
      check_int("byte_rise", n_rise - s_rise, 9);
      check_int("byte_fall", n_fall - s_fall, 9);
      check_int("byte_startstop", (n_start - s_start) + (n_stop - s_stop), 0);
      check_int("byte_busy", int'(busy_o), 1);

      // Repeated START while busy.
      drive(0, b, 5);
      drive(0, 1, 5);
      drive(1, 1, 10);
      snap();
      drive(1, 0, 12);
      check_int("rstart_count", n_start - s_start, 1);
      check_int("rstart_busy", int'(busy_o), 1);

      // Two-cycle SDA spike with SCL high is rejected.
      drive(0, 0, 5);
      drive(0, 1, 5);
      drive(1, 1, 10);
      snap();
      drive(1, 0, 2);
      drive(1, 1, 12);
      check_int("spike2_glitch", n_glitch - s_glitch, 1);
      check_int("spike2_start", n_start - s_start, 0);
      check_int("spike2_sda", int'(sda_o), 1);

      // Three-cycle spike is accepted: START, then the return high is a STOP.
      snap();
      drive(1, 0, 3);
      drive(1, 1, 12);
      check_int("spike3_start", n_start - s_start, 1);
      check_int("spike3_stop", n_stop - s_stop, 1);
      check_int("spike3_busy", int'(busy_o), 0);

      // STOP while idle.
      drive(0, 1, 5);
      drive(0, 0, 5);
      drive(1, 0, 10);
      snap();
      drive(1, 1, 12);
      check_int("idle_stop_count", n_stop - s_stop, 1);
      check_int("idle_stop_busy", int'(busy_o), 0);

      // Both lines fall together: SCL fall only, no START.
      snap();
      drive(0, 0, 12);
      check_int("simul_fall", n_fall - s_fall, 1);
      check_int("simul_start", n_start - s_start, 0);

      // Reset in the middle of filtering a SDA rise.
      drive(1, 0, 12);
      sda_i = 1'b1;
      repeat (4) @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      check_vec("reset_async", out_vec(), RST_V);
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      snap();
      drive(1, 1, 20);
      check_int("post_reset_events", (n_rise - s_rise) + (n_fall - s_fall) + (n_start - s_start)
                + (n_stop - s_stop) + (n_glitch - s_glitch), 0);

      // Randomised levels and hold times around the filter threshold.
      for (int k = 0; k < 400; k++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 6)));
         if (k == 200) begin
            rst_ni = 1'b0;
            #1;
            check_vec("reset_random", out_vec(), RST_V);
            @(negedge clk_i);
            rst_ni = 1'b1;
         end
      end
      drive(1, 1, 15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2c_line_filter.md
# i2c_line_filter

Input conditioning stage for the I2C target, consuming the SCL/SDA levels read back from the open-drain pads. It synchronises both lines into the system clock domain and rejects spikes shorter than a programmable number of cycles. It also produces clean levels, SCL edge pulses, START/STOP pulses and a bus-busy flag for the downstream protocol engine. It never drives the pads; the pad drivers stay open-drain (`1'bz` / `1'b0`) elsewhere.

## Interface

- `filter_len`, default 3: consecutive synchronised cycles a new level must persist before it is accepted; legal range 1..15.
- `clk_i`  input  1  system clock (27 MHz on board).
- `rst_ni`  input  1  reset; asynchronous and active-low. One clock domain only.
- `scl_i`  input  1  raw SCL pad read-back, asynchronous to `clk_i`.
- `sda_i`  input  1  raw SDA pad read-back, asynchronous to `clk_i`.
- `scl_o`  output  1  filtered SCL level; reset 1.
- `sda_o`  output  1  filtered SDA level; reset 1.
- `scl_rise_o`  output  1  one-cycle pulse on filtered SCL 0->1; reset 0.
- `scl_fall_o`  output  1  one-cycle pulse on filtered SCL 1->0; reset 0.
- `start_o`  output  1  one-cycle pulse on START or repeated START; reset 0.
- `stop_o`  output  1  one-cycle pulse on STOP; reset 0.
- `busy_o`  output  1  bus-busy level; reset 0.
- `glitch_o`  output  1  one-cycle pulse when a spike on either line is rejected; reset 0.

## Operation

- **Synchroniser.** Each line passes through a 2-flop synchroniser, giving s1 then s2. Both flops reset to 1, the idle bus level.
- **Filter, per line.** The filter holds a filtered level (`filt`) and a 4-bit counter.
  - If s2 == `filt`, the counter is cleared to 0.
  - If s2 != `filt` and counter == `filter_len`-1, `filt` takes the value of s2 and the counter is cleared.
  - Otherwise, if s2 != `filt`, the counter increments.
- **Glitch detection.** The counter is nonzero and s2 returns to `filt` before acceptance. This registers a one-cycle `glitch_o` (OR of both lines).
- **Edge pulses.** These are registered and derived from the filtered levels, comparing `filt` with its previous value `filt_d`.
  - `scl_rise_o` = SCL `filt` & ~SCL `filt_d`.
  - `scl_fall_o` = the inverse condition.
- **START.** SDA `filt` 1->0 while SCL `filt` and SCL `filt_d` are both 1.
- **STOP.** SDA `filt` 0->1 while SCL `filt` and SCL `filt_d` are both 1.
- **Simultaneous change.** If filtered SCL and filtered SDA change on the same edge, no START/STOP is reported. SCL edge pulses are still reported.
- **Busy flag.**
  - `busy_o` sets on the same edge `start_o` asserts.
  - It clears on the same edge `stop_o` asserts.
  - A repeated START while busy pulses `start_o` and `busy_o` stays 1.
  - A STOP while idle pulses `stop_o` and `busy_o` stays 0.
- **Reset.** Reset asserted at any time, including mid-filter, immediately returns every register to its reset value: levels 1, counters 0, pulses 0, busy 0.
- **Release with pins low.** If the pins are low when reset releases, they are filtered as ordinary transitions from 1 and produce the corresponding fall/START pulses.

## Timing

- **Edge numbering.** Edge k is the first rising `clk_i` edge at which s1 captures a new stable raw level.
  - s2 updates at k+1.
  - `scl_o`/`sda_o` update at edge k+1+`filter_len`.
  - Edge and START/STOP pulses and the `busy_o` change are visible after edge k+2+`filter_len`, high for exactly one cycle.
- **Rejection bound.** A raw level lasting N sampled cycles:
  - is rejected if N < `filter_len`;
  - is accepted if N >= `filter_len`.
- **Glitch pulse timing.** `glitch_o` is asserted after the edge on which s2 returns to `filt`.
- **No backpressure.** Pulses are never merged or delayed. Consecutive accepted transitions on one line are at least `filter_len` cycles apart.
- **Counter width.** The counter never exceeds `filter_len`-1; no wrap.

## Test plan

All scenarios use `filter_len`=3.
- **Reset/idle.** Assert `rst_ni`=0, then release with pins high and hold 20 cycles -> `scl_o`=`sda_o`=1, all pulses 0, `busy_o`=0 throughout.
- **START.** SCL held 1, SDA driven 0 so s1 samples it at edge 10 -> `sda_o`=0 after edge 14; `start_o` high one cycle after edge 15; `busy_o`=1 from edge 15.
- **Spike rejection.** With the bus busy, SDA low for exactly 2 sampled cycles (edges 10-11) with SCL high -> `sda_o` stays 1, `glitch_o` one cycle after edge 14, no `start_o`. Repeat with a 3-cycle spike -> accepted, `start_o` pulses.
- **Byte clocking.** After START, SCL toggles with period 20 cycles for 9 clocks, SDA changing only while SCL is 0 -> 9 `scl_rise_o` and 9 `scl_fall_o` pulses, no `start_o`/`stop_o`, `busy_o` stays 1.
- **Repeated START, then STOP.**
  - Repeated START -> `start_o` pulses, `busy_o` stays 1.
  - SDA 0->1 with SCL high -> `stop_o` one cycle, `busy_o`=0.
  - Second STOP -> `stop_o` pulses, `busy_o` stays 0.
- **Simultaneous change and reset.**
  - SCL and SDA both fall on the same sampled edge -> `scl_fall_o` only, no START.
  - Assert reset while the filter counter=2 -> all outputs return to reset values at once, no pulses after release with pins high.
